if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction, PC and address width.
REQ-002 SHALL have parameter PC_INC, default 1: PC increment per fetched instruction (word-addressed).
REQ-003 SHALL have parameter NOP_WORD, default all-zero WIDTH bits: flush/reset value loaded into IR_ID.
REQ-004 SHALL have parameter HALT_OP, default 6'h3F: opcode (IR[31:26]) that halts fetch.
REQ-005 SHALL have a single clock and a synchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 IsStall_IF  in  1  hazard unit: hold fetch.
REQ-009 IsStall_ID  in  1  hazard unit: hold IR_ID/PC_ID.
REQ-010 br_taken  in  1  redirect request from a later stage.
REQ-011 br_target  in  WIDTH  redirect PC.
REQ-012 imem_req  out  1  instruction-memory request.
REQ-013 imem_addr  out  WIDTH  fetch address.
REQ-014 imem_ack  in  1  memory returns data this cycle.
REQ-015 imem_rdata  in  WIDTH  fetched instruction.
REQ-016 IR_ID  out  WIDTH  instruction presented to ID.
REQ-017 PC_ID  out  WIDTH  PC of IR_ID.
REQ-018 bubble_EXE  out  1  ID/EXE register must load a NOP this cycle.
REQ-019 halted  out  1  fetch stopped on HALT_OP.

Function
REQ-020 States SHALL be FETCH, HOLD, DROP, HALTED; stall = IsStall_IF | IsStall_ID.
REQ-021 Memory handshake: imem_req, once high, SHALL stay high with imem_addr stable until the cycle imem_ack=1.
REQ-022 FETCH: imem_req=1, imem_addr=PC; on imem_ack & !stall -> IR_ID<=imem_rdata, PC_ID<=PC, PC<=PC+PC_INC, stay FETCH (1 instr/cycle with zero-wait memory).
REQ-023 FETCH, imem_ack & stall: rdata captured into a one-entry buffer, PC<=PC+PC_INC, IR_ID/PC_ID unchanged, -> HOLD.
REQ-024 FETCH, no ack: PC, IR_ID, PC_ID unchanged.
REQ-025 HOLD: imem_req=0; when stall=0 -> IR_ID<=buffer, PC_ID<=buffered PC, -> FETCH next cycle.
REQ-026 Any state, stall=1: IR_ID and PC_ID SHALL hold.
REQ-027 bubble_EXE SHALL equal IsStall_ID combinationally, and SHALL be 1 in any cycle where br_taken=1.
REQ-028 br_taken SHALL take priority over stall: PC<=br_target, IR_ID<=NOP_WORD, PC_ID<=0, buffer discarded.
REQ-029 br_taken in FETCH with imem_req=1 & imem_ack=0: -> DROP; DROP keeps the old request until imem_ack, discards that rdata, then -> FETCH at br_target.
REQ-030 br_taken coincident with imem_ack: rdata discarded, -> FETCH at br_target next cycle.
REQ-031 Word loaded into IR_ID with IR[31:26]==HALT_OP -> HALTED: imem_req=0, halted=1, PC frozen.
REQ-032 HALTED: br_taken SHALL exit to FETCH at br_target with halted<=0 and IR_ID<=NOP_WORD; otherwise only reset exits.
REQ-033 PC arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-034 Reset SHALL give state FETCH, PC=0, IR_ID=NOP_WORD, PC_ID=0, halted=0, buffer empty; imem_req=0 during the reset cycle.
REQ-035 Reset mid-request (any state) SHALL abandon the transaction; an ack in the first post-reset cycle SHALL be ignored unless imem_req=1 that cycle.

Verification
REQ-036 Zero-wait memory, rdata=PC*2, no stalls -> IR_ID = 0,2,4,... one per cycle; PC_ID = 0,1,2.
REQ-037 IsStall_IF=IsStall_ID=1 for 3 cycles with ack during the first -> IR_ID held 3 cycles, bubble_EXE=1 for 3 cycles, then buffered word appears with no instruction lost or duplicated.
REQ-038 br_taken, br_target=0x100, while request pending ack-delayed 2 cycles -> late rdata discarded, next imem_addr=0x100, IR_ID=NOP_WORD meanwhile.
REQ-039 Fetch word 0xFC000000 -> halted=1 next cycle, imem_req=0 thereafter; then br_taken to 0x20 -> halted=0, fetch resumes at 0x20.
REQ-040 PC=0xFFFFFFFF fetched -> next imem_addr=0x00000000; reset asserted during stall -> all REQ-034 values next cycle.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction-memory handshake, owns the PC,
// and presents IR_ID/PC_ID to decode with stall, redirect and halt handling.
module if_stage #(
    parameter int               WIDTH    = 32,
    parameter int               PC_INC   = 1,
    parameter logic [WIDTH-1:0] NOP_WORD = {WIDTH{1'b0}},
    parameter logic [5:0]       HALT_OP  = 6'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IsStall_IF,
    input  logic             IsStall_ID,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] IR_ID,
    output logic [WIDTH-1:0] PC_ID,
    output logic             bubble_EXE,
    output logic             halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] pc_r, pc_s;
    logic [WIDTH-1:0] ir_r, ir_s;
    logic [WIDTH-1:0] pc_id_r, pc_id_s;
    logic [WIDTH-1:0] buf_ir_r, buf_ir_s;
    logic [WIDTH-1:0] buf_pc_r, buf_pc_s;
    logic [WIDTH-1:0] drop_addr_r, drop_addr_s;
    logic             halted_r, halted_s;
    logic             stall_s;

    function automatic logic is_halt(input logic [WIDTH-1:0] word);
        return word[WIDTH-1 -: 6] == HALT_OP;
    endfunction

    assign stall_s    = IsStall_IF | IsStall_ID;
    assign bubble_EXE = IsStall_ID | br_taken;
    // DROP keeps presenting the abandoned address until memory acknowledges it.
    assign imem_req   = ~reset & ((state_r == FETCH) | (state_r == DROP));
    assign imem_addr  = (state_r == DROP) ? drop_addr_r : pc_r;
    assign IR_ID      = ir_r;
    assign PC_ID      = pc_id_r;
    assign halted     = halted_r;

    // Next-state and datapath update; redirect always wins over stall.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        ir_s        = ir_r;
        pc_id_s     = pc_id_r;
        buf_ir_s    = buf_ir_r;
        buf_pc_s    = buf_pc_r;
        drop_addr_s = drop_addr_r;
        halted_s    = halted_r;
        case (state_r)
            FETCH: begin
                if (br_taken) begin
                    pc_s    = br_target;
                    ir_s    = NOP_WORD;
                    pc_id_s = ZERO_W;
                    if (imem_ack) begin
                        state_s = FETCH;
                    end else begin
                        state_s     = DROP;
                        drop_addr_s = pc_r;
                    end
                end else if (imem_ack) begin
                    pc_s = pc_r + PC_STEP;
                    if (stall_s) begin
                        buf_ir_s = imem_rdata;
                        buf_pc_s = pc_r;
                        state_s  = HOLD;
                    end else begin
                        ir_s    = imem_rdata;
                        pc_id_s = pc_r;
                        if (is_halt(imem_rdata)) begin
                            state_s  = HALTED;
                            halted_s = 1'b1;
                        end else begin
                            state_s = FETCH;
                        end
                    end
                end else begin
                    state_s = FETCH;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_s    = br_target;
                    ir_s    = NOP_WORD;
                    pc_id_s = ZERO_W;
                    state_s = FETCH;
                end else if (!stall_s) begin
                    ir_s    = buf_ir_r;
                    pc_id_s = buf_pc_r;
                    if (is_halt(buf_ir_r)) begin
                        state_s  = HALTED;
                        halted_s = 1'b1;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DROP: begin
                if (br_taken) begin
                    pc_s    = br_target;
                    ir_s    = NOP_WORD;
                    pc_id_s = ZERO_W;
                    state_s = imem_ack ? FETCH : DROP;
                end else if (imem_ack) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            HALTED: begin
                if (br_taken) begin
                    pc_s     = br_target;
                    ir_s     = NOP_WORD;
                    pc_id_s  = ZERO_W;
                    halted_s = 1'b0;
                    state_s  = FETCH;
                end else begin
                    state_s = HALTED;
                end
            end
            default: begin
                state_s = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= FETCH;
            pc_r        <= ZERO_W;
            ir_r        <= NOP_WORD;
            pc_id_r     <= ZERO_W;
            buf_ir_r    <= ZERO_W;
            buf_pc_r    <= ZERO_W;
            drop_addr_r <= ZERO_W;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            ir_r        <= ir_s;
            pc_id_r     <= pc_id_s;
            buf_ir_r    <= buf_ir_s;
            buf_pc_r    <= buf_pc_s;
            drop_addr_r <= drop_addr_s;
            halted_r    <= halted_s;
        end
    end

endmodule
